// File: rtl/ahb_apb_bridge.sv
// AHB-to-APB bridge: one APB SETUP/ACCESS transaction per selected AHB
// transfer, HREADY held low until it completes, PREADY timeout guard.
module ahb_apb_bridge #(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_D000,
    parameter int          NUM_APB    = 4,
    parameter int          TIMEOUT    = 255
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HSEL,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic                    HWRITE,
    input  logic [3:0]              HBE,
    input  logic [31:0]             HWDATA,
    output logic [31:0]             HRDATA,
    output logic                    HREADY,
    output logic [NUM_APB-1:0]      PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [11:0]             PADDR,
    output logic [31:0]             PWDATA,
    output logic [3:0]              PSTRB,
    input  logic [NUM_APB*32-1:0]   PRDATA,
    input  logic [NUM_APB-1:0]      PREADY,
    input  logic [NUM_APB-1:0]      PSLVERR,
    output logic                    bus_err
);

    localparam int SW = (NUM_APB > 1) ? $clog2(NUM_APB) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Value of the counter during the last ACCESS cycle allowed before abort
    localparam logic [CW-1:0]         CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_DONE} state_t;

    state_t                     state, state_n;
    logic [SW-1:0]              slot;
    logic [CW-1:0]              cnt;

    // Slot decode: unsigned offset from the base, 4 KiB per slot. An address
    // below the base wraps to a huge offset but is rejected explicitly too.
    logic [ADDR_WIDTH-1:0]      offs, slot_full;
    logic                       hit;
    logic [SW-1:0]              slot_n;

    assign offs      = HADDR - BASE;
    assign slot_full = offs >> 12;
    assign hit       = (HADDR >= BASE) && (slot_full < ADDR_WIDTH'(NUM_APB));
    assign slot_n    = slot_full[SW-1:0];

    // Per-slot view of the APB return signals, muxed by the latched slot
    logic [NUM_APB-1:0][31:0]   prdata_a;
    logic [31:0]                prdata_sel;
    logic                       pready_sel, pslverr_sel;

    assign prdata_a    = PRDATA;
    assign prdata_sel  = prdata_a[slot];
    assign pready_sel  = PREADY[slot];
    assign pslverr_sel = PSLVERR[slot];

    logic apb_act;
    assign apb_act = (state == S_SETUP) || (state == S_ACCESS);

    // One-hot slot select, live only during SETUP and ACCESS
    for (genvar i = 0; i < NUM_APB; i++) begin : g_psel
        assign PSEL[i] = apb_act && (slot == SW'(i));
    end

    assign PENABLE = (state == S_ACCESS);
    assign HREADY  = (state == S_IDLE) || (state == S_DONE);

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= S_IDLE;
        else          state <= state_n;
    end

    // Next-state: new work is accepted only from IDLE
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (HSEL) state_n = hit ? S_SETUP : S_DONE;
            S_SETUP:  state_n = S_ACCESS;
            S_ACCESS: if (pready_sel || (cnt == CNT_LAST)) state_n = S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Request capture, ACCESS counter, response capture and the error pulse
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            slot    <= '0;
            cnt     <= '0;
            PADDR   <= '0;
            PWRITE  <= 1'b0;
            PWDATA  <= '0;
            PSTRB   <= '0;
            HRDATA  <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                S_IDLE: if (HSEL) begin
                    slot   <= slot_n;
                    PADDR  <= {HADDR[11:2], 2'b00};
                    PWRITE <= HWRITE;
                    PWDATA <= HWDATA;
                    PSTRB  <= HWRITE ? HBE : 4'b0000;
                    cnt    <= '0;
                    if (!hit) begin
                        HRDATA  <= '0;
                        bus_err <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    cnt <= cnt + CW'(1);
                    if (pready_sel) begin
                        HRDATA  <= PWRITE ? 32'h0 : prdata_sel;
                        bus_err <= pslverr_sel;
                    end else if (cnt == CNT_LAST) begin
                        HRDATA  <= '0;
                        bus_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Bench for ahb_apb_bridge: scripted transfers against a simple APB slave
// model; expected responses queued on issue and popped at DONE.
module tb_ahb_apb_bridge;

    localparam int NUM_APB = 4;
    localparam int TIMEOUT = 255;

    logic                  HCLK = 1'b0;
    logic                  HRESETn;
    logic                  HSEL;
    logic [31:0]           HADDR;
    logic                  HWRITE;
    logic [3:0]            HBE;
    logic [31:0]           HWDATA;
    logic [31:0]           HRDATA;
    logic                  HREADY;
    logic [NUM_APB-1:0]    PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [11:0]           PADDR;
    logic [31:0]           PWDATA;
    logic [3:0]            PSTRB;
    logic [NUM_APB*32-1:0] PRDATA;
    logic [NUM_APB-1:0]    PREADY;
    logic [NUM_APB-1:0]    PSLVERR;
    logic                  bus_err;

    ahb_apb_bridge #(
        .ADDR_WIDTH(32), .BASE_ADDR(32'h4000_D000), .NUM_APB(NUM_APB), .TIMEOUT(TIMEOUT)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HBE(HBE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .bus_err(bus_err)
    );

    always #5 HCLK = ~HCLK;

    // APB slave model: slot i is ready after wait_n[i] ACCESS cycles unless stuck
    logic [7:0]         wait_n [NUM_APB];
    logic [NUM_APB-1:0] stuck;
    logic [NUM_APB-1:0] err_cfg;
    logic [7:0]         acc_cnt;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)     acc_cnt <= 8'd0;
        else if (PENABLE) acc_cnt <= acc_cnt + 8'd1;
        else              acc_cnt <= 8'd0;
    end

    always_comb begin
        PREADY = '0;
        for (int i = 0; i < NUM_APB; i++) PREADY[i] = !stuck[i] && (acc_cnt >= wait_n[i]);
        PSLVERR = err_cfg;
    end

    typedef struct { logic [31:0] rdata; logic err; } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Observations of the most recent transfer
    int          obs_low, obs_en, obs_setups;
    logic [3:0]  obs_psel_or, obs_first_psel;
    logic        obs_first_pen, obs_pwrite;
    logic [11:0] obs_paddr;
    logic [3:0]  obs_pstrb;
    logic [31:0] obs_pwdata;

    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                        input bit hold);
        exp_t e;
        bit   done;
        e.rdata = exp_rd;
        e.err   = exp_err;
        sb.push_back(e);
        @(negedge HCLK);
        HSEL = 1'b1; HADDR = addr; HWRITE = wr; HWDATA = wdata; HBE = be;
        @(posedge HCLK);
        #1;
        if (!hold) HSEL = 1'b0;
        obs_low = 0; obs_en = 0; obs_setups = 0; obs_psel_or = '0;
        obs_first_psel = '0; obs_first_pen = 1'b0;
        obs_paddr = '0; obs_pstrb = '0; obs_pwdata = '0; obs_pwrite = 1'b0;
        done = 1'b0;
        for (int c = 1; c <= TIMEOUT + 20 && !done; c++) begin
            @(negedge HCLK);
            if (c == 1) begin obs_first_psel = PSEL; obs_first_pen = PENABLE; end
            obs_psel_or |= PSEL;
            if (PSEL != '0 && !PENABLE) obs_setups++;
            if (PENABLE) begin
                obs_en++;
                obs_paddr = PADDR; obs_pstrb = PSTRB; obs_pwdata = PWDATA; obs_pwrite = PWRITE;
            end
            if (HREADY) done = 1'b1;
            else        obs_low++;
        end
        HSEL = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_bound: addr %h never completed, expected DONE", addr);
        end else begin
            checks++;
            if (HRDATA !== e.rdata) begin
                errors++;
                $display("FAIL hrdata: addr %h got %h expected %h", addr, HRDATA, e.rdata);
            end
            checks++;
            if (bus_err !== e.err) begin
                errors++;
                $display("FAIL bus_err: addr %h got %b expected %b", addr, bus_err, e.err);
            end
            @(negedge HCLK);
            checks++;
            if (bus_err !== 1'b0) begin
                errors++;
                $display("FAIL bus_err_pulse: after DONE got %b expected 0", bus_err);
            end
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HBE = '0; HWDATA = '0;
        stuck = '0; err_cfg = '0;
        for (int i = 0; i < NUM_APB; i++) wait_n[i] = 8'd0;
        #2;
        checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL rst_hready: got %b expected 1", HREADY); end
        checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL rst_hrdata: got %h expected 0", HRDATA); end
        checks++; if (PSEL !== 4'h0) begin errors++; $display("FAIL rst_psel: got %b expected 0000", PSEL); end
        checks++; if (PENABLE !== 1'b0) begin errors++; $display("FAIL rst_penable: got %b expected 0", PENABLE); end
        checks++; if (PWRITE !== 1'b0) begin errors++; $display("FAIL rst_pwrite: got %b expected 0", PWRITE); end
        checks++; if (PADDR !== 12'h0) begin errors++; $display("FAIL rst_paddr: got %h expected 0", PADDR); end
        checks++; if (PWDATA !== 32'h0) begin errors++; $display("FAIL rst_pwdata: got %h expected 0", PWDATA); end
        checks++; if (PSTRB !== 4'h0) begin errors++; $display("FAIL rst_pstrb: got %b expected 0000", PSTRB); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err: got %b expected 0", bus_err); end
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
    endtask

    task automatic test_write_slot0();
        xfer(32'h4000_D004, 1'b1, 32'h0000_0041, 4'b0001, 32'h0, 1'b0, 1'b0);
        checks++; if (obs_first_psel !== 4'b0001) begin errors++; $display("FAIL wr_setup_psel: got %b expected 0001", obs_first_psel); end
        checks++; if (obs_first_pen !== 1'b0) begin errors++; $display("FAIL wr_setup_penable: got %b expected 0", obs_first_pen); end
        checks++; if (obs_en != 1) begin errors++; $display("FAIL wr_access_cycles: got %0d expected 1", obs_en); end
        checks++; if (obs_paddr !== 12'h004) begin errors++; $display("FAIL wr_paddr: got %h expected 004", obs_paddr); end
        checks++; if (obs_pstrb !== 4'b0001) begin errors++; $display("FAIL wr_pstrb: got %b expected 0001", obs_pstrb); end
        checks++; if (obs_pwdata !== 32'h41) begin errors++; $display("FAIL wr_pwdata: got %h expected 00000041", obs_pwdata); end
        checks++; if (obs_pwrite !== 1'b1) begin errors++; $display("FAIL wr_pwrite: got %b expected 1", obs_pwrite); end
        checks++; if (obs_low != 2) begin errors++; $display("FAIL wr_latency: hready low %0d cycles, expected 2", obs_low); end
    endtask

    task automatic test_read_wait();
        wait_n[1] = 8'd3;
        xfer(32'h4000_E008, 1'b0, 32'hFFFF_FFFF, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b0);
        wait_n[1] = 8'd0;
        checks++; if (obs_low != 5) begin errors++; $display("FAIL rd_latency: hready low %0d cycles, expected 5", obs_low); end
        checks++; if (obs_psel_or !== 4'b0010) begin errors++; $display("FAIL rd_psel: got %b expected 0010", obs_psel_or); end
        checks++; if (obs_pstrb !== 4'b0000) begin errors++; $display("FAIL rd_pstrb: got %b expected 0000", obs_pstrb); end
        checks++; if (obs_paddr !== 12'h008) begin errors++; $display("FAIL rd_paddr: got %h expected 008", obs_paddr); end
    endtask

    task automatic test_pslverr();
        err_cfg[2] = 1'b1;
        xfer(32'h4000_F000, 1'b0, 32'h0, 4'b1111, 32'h2222_BEEF, 1'b1, 1'b0);
        err_cfg[2] = 1'b0;
        checks++; if (obs_psel_or !== 4'b0100) begin errors++; $display("FAIL err_psel: got %b expected 0100", obs_psel_or); end
    endtask

    task automatic test_unmapped();
        xfer(32'h4001_1000, 1'b0, 32'h0, 4'b1111, 32'h0, 1'b1, 1'b0);
        checks++; if (obs_low != 0) begin errors++; $display("FAIL unmap_latency: hready low %0d cycles, expected 0", obs_low); end
        checks++; if (obs_psel_or !== 4'b0000) begin errors++; $display("FAIL unmap_psel: got %b expected 0000", obs_psel_or); end
        xfer(32'h4000_C000, 1'b1, 32'h1234_5678, 4'b1111, 32'h0, 1'b1, 1'b0);
        checks++; if (obs_psel_or !== 4'b0000) begin errors++; $display("FAIL below_base_psel: got %b expected 0000", obs_psel_or); end
        checks++; if (obs_low != 0) begin errors++; $display("FAIL below_base_latency: hready low %0d cycles, expected 0", obs_low); end
    endtask

    task automatic test_unaligned();
        xfer(32'h4000_F00B, 1'b1, 32'hA5A5_0000, 4'b1000, 32'h0, 1'b0, 1'b0);
        checks++; if (obs_paddr !== 12'h008) begin errors++; $display("FAIL unal_paddr: got %h expected 008", obs_paddr); end
        checks++; if (obs_pstrb !== 4'b1000) begin errors++; $display("FAIL unal_pstrb: got %b expected 1000", obs_pstrb); end
        checks++; if (obs_psel_or !== 4'b0100) begin errors++; $display("FAIL unal_psel: got %b expected 0100", obs_psel_or); end
    endtask

    task automatic test_timeout();
        stuck[3] = 1'b1;
        xfer(32'h4001_0010, 1'b0, 32'h0, 4'b1111, 32'h0, 1'b1, 1'b1);
        stuck[3] = 1'b0;
        checks++; if (obs_en != TIMEOUT) begin errors++; $display("FAIL to_penable: high %0d cycles, expected %0d", obs_en, TIMEOUT); end
        checks++; if (obs_setups != 1) begin errors++; $display("FAIL to_setups: got %0d expected 1", obs_setups); end
        checks++; if (obs_low != TIMEOUT + 1) begin errors++; $display("FAIL to_latency: hready low %0d, expected %0d", obs_low, TIMEOUT + 1); end
        checks++; if (obs_psel_or !== 4'b1000) begin errors++; $display("FAIL to_psel: got %b expected 1000", obs_psel_or); end
    endtask

    task automatic test_reset_mid();
        stuck[1] = 1'b1;
        @(negedge HCLK);
        HSEL = 1'b1; HADDR = 32'h4000_E000; HWRITE = 1'b0; HBE = 4'hF;
        @(posedge HCLK);
        #1 HSEL = 1'b0;
        repeat (4) @(negedge HCLK);
        checks++; if (PENABLE !== 1'b1) begin errors++; $display("FAIL mid_in_access: penable %b expected 1", PENABLE); end
        #3 HRESETn = 1'b0;
        #1;
        checks++; if (PSEL !== 4'h0) begin errors++; $display("FAIL mid_rst_psel: got %b expected 0000", PSEL); end
        checks++; if (PENABLE !== 1'b0) begin errors++; $display("FAIL mid_rst_penable: got %b expected 0", PENABLE); end
        checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL mid_rst_hready: got %b expected 1", HREADY); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL mid_rst_bus_err: got %b expected 0", bus_err); end
        @(negedge HCLK);
        HRESETn = 1'b1;
        stuck[1] = 1'b0;
        repeat (2) @(negedge HCLK);
        checks++; if (PSEL !== 4'h0) begin errors++; $display("FAIL mid_no_resume: psel %b expected 0000", PSEL); end
        xfer(32'h4000_E004, 1'b0, 32'h0, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b0);
        checks++; if (obs_low != 2) begin errors++; $display("FAIL mid_after_latency: hready low %0d, expected 2", obs_low); end
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        logic [7:0] setup_mask;
        e.rdata = 32'h1111_0000; e.err = 1'b0;
        sb.push_back(e);
        sb.push_back(e);
        setup_mask = '0;
        @(negedge HCLK);
        HSEL = 1'b1; HADDR = 32'h4000_D010; HWRITE = 1'b0; HBE = 4'hF;
        for (int c = 1; c <= 8; c++) begin
            @(negedge HCLK);
            if (PSEL != '0 && !PENABLE) setup_mask[c-1] = 1'b1;
            if (c == 3 || c == 7) begin
                e = sb.pop_front();
                checks++;
                if (HREADY !== 1'b1 || HRDATA !== e.rdata || bus_err !== e.err) begin
                    errors++;
                    $display("FAIL b2b_done_c%0d: hready %b hrdata %h bus_err %b, expected 1 %h %b",
                             c, HREADY, HRDATA, bus_err, e.rdata, e.err);
                end
            end
            if (c == 7) HSEL = 1'b0;
        end
        checks++;
        if (setup_mask !== 8'b0001_0001) begin
            errors++;
            $display("FAIL b2b_setup_cycles: got %b expected 00010001", setup_mask);
        end
    endtask

    initial begin
        PRDATA = {32'h3333_3333, 32'h2222_BEEF, 32'hCAFE_F00D, 32'h1111_0000};
        test_reset();
        test_write_slot0();
        test_read_wait();
        test_pslverr();
        test_unmapped();
        test_unaligned();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge HCLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
